// File: rtl/nexys_starship_pkg.sv
// Shared types for the starship GCD requester: one-hot FSM states and default widths.
package nexys_starship_pkg;

  localparam int unsigned GCD_WIDTH = 8;

  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_ISSUE = 5'b00010,
    ST_WAIT  = 5'b00100,
    ST_ACK   = 5'b01000,
    ST_DRAIN = 5'b10000
  } state_e;

endpackage

// File: rtl/nexys_starship_watchdog.sv
// Clear/enable cycle counter; tc_o flags the TIMEOUT-th enabled cycle since the last clear.
module nexys_starship_watchdog #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = en_i && !clr_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/nexys_starship_gcd_requester.sv
// Initiator for the GCD core Start/Done/Ack handshake: accepts operand pairs,
// drives the core, returns the result, bypasses zero operands and aborts hung cores.
module nexys_starship_gcd_requester
  import nexys_starship_pkg::*;
#(
  parameter int unsigned WIDTH   = GCD_WIDTH,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             req_valid,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             req_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_gcd,
  output logic             res_err,
  input  logic             single_step,
  input  logic             step,
  output logic [WIDTH-1:0] core_ain,
  output logic [WIDTH-1:0] core_bin,
  output logic             core_start,
  output logic             core_ack,
  output logic             core_cen,
  output logic             core_rst,
  input  logic             core_q_i,
  input  logic             core_q_done,
  input  logic [WIDTH-1:0] core_gcd,
  output logic             busy,
  output logic [CNT_W-1:0] done_count
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   ain_q, ain_d, bin_q, bin_d, res_gcd_q, res_gcd_d;
  logic               res_valid_q, res_valid_d, res_err_q, res_err_d;
  logic               core_rst_q, core_rst_d;
  logic [CNT_W-1:0]   done_count_q, done_count_d;
  logic               accept, zero_op, done_seen, timeout, wd_clr, wd_en, wd_tc;

  assign core_cen  = single_step ? step : 1'b1;
  assign accept    = req_valid && req_ready;
  assign zero_op   = (req_a == '0) || (req_b == '0);
  assign done_seen = (state_q == ST_WAIT) && core_q_done;
  assign timeout   = (state_q == ST_WAIT) && !core_q_done && wd_tc;
  assign wd_clr    = (state_q != ST_WAIT);
  assign wd_en     = (state_q == ST_WAIT) && core_cen;

  nexys_starship_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk_i (Clk),
    .rst_i (Reset),
    .clr_i (wd_clr),
    .en_i  (wd_en),
    .tc_o  (wd_tc)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Start and Ack only leave ISSUE/ACK on an enabled core cycle so a stepped core cannot miss them.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept && !zero_op) state_d = ST_ISSUE;
      ST_ISSUE: if (core_q_i && core_cen) state_d = ST_WAIT;
      ST_WAIT: begin
        if (core_q_done) begin
          state_d = ST_ACK;
        end else if (wd_tc) begin
          state_d = ST_DRAIN;
        end
      end
      ST_ACK:   if (core_cen) state_d = ST_DRAIN;
      ST_DRAIN: if (core_q_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == ST_IDLE) && !res_valid_q;
    busy       = (state_q != ST_IDLE);
    core_start = (state_q == ST_ISSUE) && core_q_i && core_cen;
    core_ack   = (state_q == ST_ACK) && core_cen;
  end

  always_comb begin
    ain_d        = ain_q;
    bin_d        = bin_q;
    res_gcd_d    = res_gcd_q;
    res_valid_d  = res_valid_q;
    res_err_d    = res_err_q;
    done_count_d = done_count_q;
    core_rst_d   = timeout;
    if (res_valid_q && res_ready) begin
      res_valid_d  = 1'b0;
      done_count_d = done_count_q + CNT_W'(1);
    end
    if (accept) begin
      ain_d = req_a;
      bin_d = req_b;
      if (zero_op) begin
        res_gcd_d   = req_a | req_b;
        res_valid_d = 1'b1;
        res_err_d   = 1'b0;
      end
    end
    if (done_seen) begin
      res_gcd_d   = core_gcd;
      res_valid_d = 1'b1;
      res_err_d   = 1'b0;
    end else if (timeout) begin
      res_gcd_d   = '0;
      res_valid_d = 1'b1;
      res_err_d   = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ain_q        <= '0;
      bin_q        <= '0;
      res_gcd_q    <= '0;
      res_valid_q  <= 1'b0;
      res_err_q    <= 1'b0;
      core_rst_q   <= 1'b0;
      done_count_q <= '0;
    end else begin
      ain_q        <= ain_d;
      bin_q        <= bin_d;
      res_gcd_q    <= res_gcd_d;
      res_valid_q  <= res_valid_d;
      res_err_q    <= res_err_d;
      core_rst_q   <= core_rst_d;
      done_count_q <= done_count_d;
    end
  end

  assign core_ain   = ain_q;
  assign core_bin   = bin_q;
  assign core_rst   = core_rst_q;
  assign res_valid  = res_valid_q;
  assign res_gcd    = res_gcd_q;
  assign res_err    = res_err_q;
  assign done_count = done_count_q;

endmodule

// File: tb/tb_nexys_starship_gcd_requester.sv
// Bench: requester driving a subtractive GCD core model, plus a second requester
// with a short watchdog driving a core that never finishes.
module tb_nexys_starship_gcd_requester;

  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          Reset, req_valid, req_ready, res_valid, res_ready, res_err;
  logic [7:0]    req_a, req_b, res_gcd, core_ain, core_bin, core_gcd;
  logic          single_step, step, core_start, core_ack, core_cen, core_rst;
  logic          core_q_i, core_q_done, busy;
  logic [CW-1:0] done_count;

  logic          w_req_valid, w_req_ready, w_res_valid, w_res_ready, w_res_err;
  logic [7:0]    w_req_a, w_req_b, w_res_gcd, w_core_ain, w_core_bin, w_core_gcd;
  logic          w_single_step, w_step, w_core_start, w_core_ack, w_core_cen, w_core_rst;
  logic          w_core_q_i, w_core_q_done, w_busy;
  logic [7:0]    w_done_count;

  nexys_starship_gcd_requester #(.WIDTH(8), .TIMEOUT(1024), .CNT_W(CW)) dut (
    .Clk(clk), .Reset(Reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .res_valid(res_valid), .res_ready(res_ready), .res_gcd(res_gcd),
    .res_err(res_err), .single_step(single_step), .step(step), .core_ain(core_ain),
    .core_bin(core_bin), .core_start(core_start), .core_ack(core_ack), .core_cen(core_cen),
    .core_rst(core_rst), .core_q_i(core_q_i), .core_q_done(core_q_done), .core_gcd(core_gcd),
    .busy(busy), .done_count(done_count)
  );

  nexys_starship_gcd_requester #(.WIDTH(8), .TIMEOUT(16), .CNT_W(8)) dut_wd (
    .Clk(clk), .Reset(Reset), .req_valid(w_req_valid), .req_a(w_req_a), .req_b(w_req_b),
    .req_ready(w_req_ready), .res_valid(w_res_valid), .res_ready(w_res_ready), .res_gcd(w_res_gcd),
    .res_err(w_res_err), .single_step(w_single_step), .step(w_step), .core_ain(w_core_ain),
    .core_bin(w_core_bin), .core_start(w_core_start), .core_ack(w_core_ack), .core_cen(w_core_cen),
    .core_rst(w_core_rst), .core_q_i(w_core_q_i), .core_q_done(w_core_q_done), .core_gcd(w_core_gcd),
    .busy(w_busy), .done_count(w_done_count)
  );

  // Subtractive GCD core: Initial -> Compute -> Done -> (Ack) -> Initial, advancing on enable.
  logic [1:0] cs;
  logic [7:0] ca, cb;
  always @(posedge clk) begin
    if (Reset || core_rst) begin
      cs <= 2'd0;
    end else if (core_cen) begin
      case (cs)
        2'd0: if (core_start) begin ca <= core_ain; cb <= core_bin; cs <= 2'd1; end
        2'd1: if (ca == cb) cs <= 2'd2; else if (ca > cb) ca <= ca - cb; else cb <= cb - ca;
        2'd2: if (core_ack) cs <= 2'd0;
        default: cs <= 2'd0;
      endcase
    end
  end
  assign core_q_i    = (cs == 2'd0);
  assign core_q_done = (cs == 2'd2);
  assign core_gcd    = ca;

  // Hung core: leaves Initial on Start and never reports Done.
  logic w_hung;
  always @(posedge clk) begin
    if (Reset || w_core_rst) w_hung <= 1'b0;
    else if (w_core_cen && w_core_start) w_hung <= 1'b1;
  end
  assign w_core_q_i    = !w_hung;
  assign w_core_q_done = 1'b0;
  assign w_core_gcd    = 8'hA5;

  int checks = 0, errors = 0;
  int n_start = 0, n_ack = 0, n_overlap = 0, exp_done = 0;
  logic [7:0] cur_a, cur_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gcd_ref(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x, y, t;
    x = a; y = b;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return x;
  endfunction

  always @(negedge clk) begin
    if (core_start) begin
      n_start++;
      chk("start_ain", core_ain, cur_a);
      chk("start_bin", core_bin, cur_b);
    end
    if (core_ack) n_ack++;
    if ((core_start && core_ack) || (core_start && core_rst) || (core_ack && core_rst)) n_overlap++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] g,
                         input int starts, input int hold, input string name);
    int n, s0, a0;
    n = 0;
    while (!req_ready && n < 3000) begin tick(); n++; end
    chk({name, "_ready"}, req_ready, 1);
    cur_a = a; cur_b = b; s0 = n_start; a0 = n_ack;
    req_valid = 1'b1; req_a = a; req_b = b;
    tick();
    req_valid = 1'b0;
    if (starts != 0 && !single_step) chk({name, "_start_lat"}, core_start, 1);
    n = 0;
    while (!res_valid && n < 3000) begin tick(); n++; end
    chk({name, "_valid"}, res_valid, 1);
    if (starts == 0) chk({name, "_bypass_lat"}, n, 0);
    chk({name, "_gcd"}, res_gcd, g);
    chk({name, "_err"}, res_err, 0);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({name, "_hold_valid"}, res_valid, 1);
      chk({name, "_hold_gcd"}, res_gcd, g);
      chk({name, "_hold_ready"}, req_ready, 0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    exp_done = (exp_done + 1) % (1 << CW);
    chk({name, "_valid_fall"}, res_valid, 0);
    chk({name, "_done_count"}, done_count, exp_done);
    n = 0;
    while (busy && n < 100) begin tick(); n++; end
    chk({name, "_idle"}, busy, 0);
    chk({name, "_starts"}, n_start - s0, starts);
    chk({name, "_acks"}, n_ack - a0, starts);
  endtask

  typedef struct {
    logic [7:0] a, b, g;
    int starts, hold;
  } vec_t;
  vec_t tbl[9];

  initial begin
    int step_cnt = 0;
    step = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      step_cnt++;
      step = single_step && (step_cnt % 4 == 0);
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int n;
    logic [7:0] ra, rb;
    logic quiet;
    Reset = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; res_ready = 1'b0; single_step = 1'b0;
    w_req_valid = 1'b0; w_req_a = '0; w_req_b = '0; w_res_ready = 1'b0;
    w_single_step = 1'b0; w_step = 1'b0;
    cur_a = '0; cur_b = '0;
    repeat (3) tick();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_gcd", res_gcd, 0);
    chk("rst_res_err", res_err, 0);
    chk("rst_ain", core_ain, 0);
    chk("rst_bin", core_bin, 0);
    chk("rst_start_ack_rst", {core_start, core_ack, core_rst}, 0);
    chk("rst_done_count", done_count, 0);
    chk("rst_busy", busy, 0);
    Reset = 1'b0;
    tick();
    chk("cen_free_run", core_cen, 1);

    tbl[0] = '{8'd36,  8'd24,  8'd12,  1, 0};
    tbl[1] = '{8'd0,   8'd15,  8'd15,  0, 0};
    tbl[2] = '{8'd0,   8'd0,   8'd0,   0, 0};
    tbl[3] = '{8'd200, 8'd0,   8'd200, 0, 0};
    tbl[4] = '{8'd17,  8'd5,   8'd1,   1, 20};
    tbl[5] = '{8'd255, 8'd255, 8'd255, 1, 0};
    tbl[6] = '{8'd1,   8'd255, 8'd1,   1, 0};
    tbl[7] = '{8'd128, 8'd96,  8'd32,  1, 0};
    tbl[8] = '{8'd91,  8'd35,  8'd7,   1, 0};
    for (int i = 0; i < 9; i++)
      run_txn(tbl[i].a, tbl[i].b, tbl[i].g, tbl[i].starts, tbl[i].hold, $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 5) == 0) ra = '0;
      run_txn(ra, rb, gcd_ref(ra, rb), (ra != 0 && rb != 0) ? 1 : 0, 0, $sformatf("rnd%0d", i));
    end

    single_step = 1'b1;
    tick();
    chk("cen_follows_step", core_cen, step);
    run_txn(8'd48, 8'd18, 8'd6, 1, 0, "single_step");
    single_step = 1'b0;

    w_req_valid = 1'b1; w_req_a = 8'd50; w_req_b = 8'd20;
    tick();
    w_req_valid = 1'b0;
    n = 0;
    while (!w_core_start && n < 10) begin tick(); n++; end
    chk("wd_start", w_core_start, 1);
    n = 0;
    do begin tick(); n++; end while (!w_core_rst && n < 40);
    chk("wd_rst_delay", n, 17);
    chk("wd_valid", w_res_valid, 1);
    chk("wd_err", w_res_err, 1);
    chk("wd_gcd", w_res_gcd, 0);
    tick();
    chk("wd_rst_pulse", w_core_rst, 0);
    w_res_ready = 1'b1;
    tick();
    w_res_ready = 1'b0;
    chk("wd_done_count", w_done_count, 1);

    n = 0;
    while (!w_req_ready && n < 20) begin tick(); n++; end
    w_req_valid = 1'b1; w_req_a = 8'd7; w_req_b = 8'd3;
    tick();
    w_req_valid = 1'b0;
    n = 0;
    while (!w_core_start && n < 10) begin tick(); n++; end
    tick();
    w_single_step = 1'b1;
    quiet = 1'b1;
    repeat (100) begin
      tick();
      if (w_core_rst || w_res_valid) quiet = 1'b0;
    end
    chk("wd_stall_no_timeout", quiet, 1);
    w_single_step = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!w_core_rst && n < 40);
    chk("wd_resume_delay", n, 16);
    chk("wd_resume_err", w_res_err, 1);
    w_res_ready = 1'b1;
    tick();
    w_res_ready = 1'b0;
    chk("wd_done_count2", w_done_count, 2);

    n = 0;
    while (!req_ready && n < 20) begin tick(); n++; end
    cur_a = 8'd200; cur_b = 8'd3;
    req_valid = 1'b1; req_a = 8'd200; req_b = 8'd3;
    tick();
    req_valid = 1'b0;
    repeat (6) tick();
    chk("mid_busy", busy, 1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    exp_done = 0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_req_ready", req_ready, 1);
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_res_gcd", res_gcd, 0);
    chk("mid_rst_ain_bin", {core_ain, core_bin}, 0);
    chk("mid_rst_pulses", {core_start, core_ack, core_rst}, 0);
    chk("mid_rst_done_count", done_count, 0);
    run_txn(8'd9, 8'd6, 8'd3, 1, 0, "post_rst");

    chk("no_overlap", n_overlap, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
